sha256_round_engine: RTL

//  Iterative SHA-256 compression core, parametrised in rounds per clock. Accepts one 512-bit

---
 rtl/sha256_round_engine.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression core: RPC rounds per clock, 16-word rolling message schedule.
// Define SHA_MIDSTATE_EN to add in_state (caller-supplied chaining value); otherwise the FIPS H(0) IV is used.
module sha256_round_engine #(
    parameter int RPC = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
`ifdef SHA_MIDSTATE_EN
    input  logic [255:0] in_state,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_hash,
    output logic         busy
);
    localparam int NCYC  = 64 / RPC;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

    localparam logic [255:0] STD_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : gBadRpc
        $error("sha256_round_engine: RPC=%0d is not one of 1,2,4,8,16", RPC);
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        work_q   [8];
    logic [31:0]        work_d   [8];
    logic [31:0]        iv_q     [8];
    logic [31:0]        window_q [16];
    logic [31:0]        window_d [16];
    logic [31:0]        ext      [16+RPC];
    logic [255:0]       hash_q;
    logic [255:0]       ivIn;
    logic [5:0]         rIdx;
    logic [31:0]        t1, t2;

`ifdef SHA_MIDSTATE_EN
    assign ivIn = in_state;
`else
    assign ivIn = STD_IV;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_hash  = hash_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ROUND;
                    cnt_d   = '0;
                end
            end
            ROUND: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ext[0..15] is W[t..t+15]; ext[16..] extends the schedule far enough to refill the window after RPC rounds.
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = window_q[i];
        for (int j = 0; j < RPC; j++)
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
        for (int i = 0; i < 8; i++) work_d[i] = work_q[i];
        rIdx = '0;
        t1   = '0;
        t2   = '0;
        for (int r = 0; r < RPC; r++) begin
            rIdx = 6'(int'(cnt_q) * RPC + r);
            t1 = work_d[7] + bsig1(work_d[4]) + ((work_d[4] & work_d[5]) ^ (~work_d[4] & work_d[6]))
                 + K[rIdx] + ext[r];
            t2 = bsig0(work_d[0]) + ((work_d[0] & work_d[1]) ^ (work_d[0] & work_d[2]) ^ (work_d[1] & work_d[2]));
            work_d[7] = work_d[6];
            work_d[6] = work_d[5];
            work_d[5] = work_d[4];
            work_d[4] = work_d[3] + t1;
            work_d[3] = work_d[2];
            work_d[2] = work_d[1];
            work_d[1] = work_d[0];
            work_d[0] = t1 + t2;
        end
        for (int i = 0; i < 16; i++) window_d[i] = ext[RPC+i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hash_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= '0;
                iv_q[i]   <= '0;
            end
            for (int i = 0; i < 16; i++) window_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && in_valid) begin
                for (int i = 0; i < 16; i++) window_q[i] <= in_block[511-32*i -: 32];
                for (int i = 0; i < 8; i++) begin
                    iv_q[i]   <= ivIn[255-32*i -: 32];
                    work_q[i] <= ivIn[255-32*i -: 32];
                end
            end else if (state_q == ROUND) begin
                work_q   <= work_d;
                window_q <= window_d;
                if (cnt_q == LAST_CNT) begin
                    for (int i = 0; i < 8; i++) hash_q[255-32*i -: 32] <= iv_q[i] + work_d[i];
                end
            end
        end
    end
endmodule
